inst_mem_loadable: RTL
======================

// Module: inst_mem_loadable
// PURPOSE
// - Parametrised, synchronous instruction memory for the RISC-V core fetch stage; successor to the fixed combinational ROM.
// - Adds a word-wide program-load port, a pipelined fetch port with a request/valid protocol, configurable read latency,
//   a per-word written bitmap, and error flagging for misaligned or out-of-range fetches.
// - Sits between the PC/fetch logic and the decode stage; the load port is driven by the debug/boot loader.
// PARAMETERS
// - ADDR_W    8             byte-address width of both ports
// - DEPTH     64            number of 32-bit words; DEPTH*4 <= 2**ADDR_W
// - READ_LAT  1             fetch latency in cycles, legal values 1 or 2
// - FILL_WORD 32'h00000013  word returned for unwritten, misaligned or out-of-range fetches (addi x0,x0,0)
// PORTS
// - clk          in   1       rising-edge clock
// - rst_n        in   1       asynchronous active-low reset
// - prog_mode    in   1       1 = loader owns memory, fetches refused
// - load_we      in   1       write strobe, honoured only in state PROG
// - load_addr    in   ADDR_W  byte address of word to write
// - load_data    in   32      instruction word to write
// - load_err     out  1       1-cycle pulse: rejected write (misaligned, out of range, or not in PROG)
// - fetch_req    in   1       fetch request, accepted when fetch_req && fetch_ready
// - fetch_addr   in   ADDR_W  byte address of fetch
// - fetch_ready  out  1       1 only in state RUN
// - fetch_valid  out  1       1-cycle pulse, READ_LAT cycles after acceptance
// - fetch_instr  out  32      instruction word, meaningful when fetch_valid
// - fetch_err    out  1       qualifies fetch_valid: misaligned or out-of-range address
// - prog_active  out  1       1 while in state PROG
// BEHAVIOUR
// - Reset (async assert, sync deassert inside): state RUN; written bitmap all 0; pipeline valid bits 0;
//   fetch_valid=0, fetch_err=0, fetch_instr=FILL_WORD, load_err=0, prog_active=0. Array contents not reset.
// - Word index = addr[ADDR_W-1:2]; misaligned = addr[1:0]!=0; out-of-range = index >= DEPTH.
// - FSM: RUN  -> DRAIN when prog_mode=1 and reads in flight; RUN -> PROG when prog_mode=1 and none in flight.
//        DRAIN -> PROG when last in-flight read has produced fetch_valid (no new fetches accepted in DRAIN).
//        PROG -> RUN when prog_mode=0; first fetch accepted in the cycle after returning to RUN.
// - Fetch: fully pipelined, one acceptance per cycle, no output backpressure; responses in request order.
//   Data = array word if index legal and bitmap bit set; FILL_WORD otherwise; fetch_err=1 if misaligned/out-of-range.
// - READ_LAT=1: registered output. READ_LAT=2: one extra register stage on data, err and valid together.
// - Load: in PROG, load_we with legal address writes array and sets bitmap bit at the clock edge;
//   illegal address or load_we outside PROG -> no write, load_err pulses next cycle. Rewrites allowed.
// - prog_mode dropping in the same cycle as a load_we: write still performed (state is PROG that cycle).
// - Reset mid-load or mid-fetch: in-flight responses discarded (no fetch_valid), bitmap cleared, so all
//   subsequent fetches return FILL_WORD until reloaded.
// STRUCTURE
// - inst_mem_pkg: FILL_WORD default, state enum {RUN, DRAIN, PROG}, helper function for index/legality check.
// - Sub-module inst_mem_array: DEPTH x 32 storage, one sync write port, one read port (no reset on data).
// - Top: FSM, written bitmap, address checks, READ_LAT pipeline, error pulses.
// TESTING
// - Reset, fetch 0x00 -> fetch_valid after READ_LAT cycles, fetch_instr=32'h00000013, fetch_err=0.
// - PROG: load 0x00<=0x0ff00083, 0x04<=0x00100113, 0x08<=0x0020f1b3; RUN, back-to-back fetch 0x00/0x04/0x08
//   -> three consecutive fetch_valid pulses with those words, in order, for READ_LAT=1 and 2.
// - Fetch 0x02 -> fetch_err=1, instr=FILL_WORD; fetch 0xFC with DEPTH=32 -> fetch_err=1; load 0x05 in PROG -> load_err=1, no write.
// - prog_mode raised with 2 fetches in flight (READ_LAT=2) -> both responses delivered, fetch_ready=0 throughout,
//   prog_active=1 the cycle after the last fetch_valid.
// - load_we in RUN -> load_err pulse, array unchanged; prog_mode falling same cycle as load_we -> word written.
// - rst_n pulse mid-fetch after loading -> no stale fetch_valid; refetch 0x00 returns 32'h00000013.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// Holds the default fill word, the controller state type and the word-legality check.
package inst_mem_pkg;

    // addi x0,x0,0 : returned for anything that is not a legal, loaded word
    localparam logic [31:0] FILL_WORD_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        PROG  = 2'd2
    } state_t;

    function automatic logic word_legal(input logic [1:0] byte_off,
                                        input int unsigned idx,
                                        input int unsigned depth);
        return (byte_off == 2'b00) && (idx < depth);
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port and one registered read port.
// Contents are deliberately not reset; validity is tracked by the owner's written bitmap.
module inst_mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory for the fetch stage: pipelined fetch port, boot-loader write
// port, per-word written bitmap and error flagging for misaligned or out-of-range accesses.
//
// state | meaning
// RUN   | fetches accepted, loads rejected
// DRAIN | loader requested, waiting for in-flight fetch responses; nothing accepted
// PROG  | loader owns the memory, fetches refused
module inst_mem_loadable
    import inst_mem_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          DEPTH     = 64,
    parameter int          READ_LAT  = 1,
    parameter logic [31:0] FILL_WORD = FILL_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_mode,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              load_err,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_err,
    output logic              prog_active
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = ADDR_W - 2;

    // Assert asynchronously, release two clocks after rst_n rises.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   f_idx;
    logic [IW-1:0]   l_idx;
    logic [AW-1:0]   f_widx;
    logic [AW-1:0]   l_widx;
    logic            f_legal;
    logic            l_legal;
    logic            fetch_acc;
    logic            load_ok;
    logic            drain_busy;
    logic            in_flight;
    logic [DEPTH-1:0] written;
    logic            v1;
    logic            err1;
    logic            use1;
    logic [31:0]     rdata;
    logic [31:0]     instr1;

    assign f_idx   = fetch_addr[ADDR_W-1:2];
    assign l_idx   = load_addr[ADDR_W-1:2];
    assign f_widx  = fetch_addr[AW+1:2];
    assign l_widx  = load_addr[AW+1:2];
    assign f_legal = word_legal(fetch_addr[1:0], 32'(f_idx), DEPTH);
    assign l_legal = word_legal(load_addr[1:0], 32'(l_idx), DEPTH);

    assign fetch_acc = fetch_req && fetch_ready;
    assign load_ok   = load_we && (state == PROG) && l_legal;
    assign in_flight = fetch_acc || drain_busy;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        fetch_ready = 1'b0;
        prog_active = 1'b0;
        unique case (state)
            RUN: begin
                fetch_ready = rst_int_n;
                if (prog_mode) begin
                    state_nxt = in_flight ? DRAIN : PROG;
                end
            end
            DRAIN: begin
                if (!drain_busy) begin
                    state_nxt = PROG;
                end
            end
            PROG: begin
                prog_active = 1'b1;
                if (!prog_mode) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            written  <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= load_we && !load_ok;
            if (load_ok) begin
                written[l_widx] <= 1'b1;
            end
        end
    end

    inst_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (load_ok),
        .waddr (l_widx),
        .wdata (load_data),
        .re    (fetch_acc && f_legal),
        .raddr (f_widx),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            v1   <= 1'b0;
            err1 <= 1'b0;
            use1 <= 1'b0;
        end else begin
            v1 <= fetch_acc;
            if (fetch_acc) begin
                err1 <= !f_legal;
                use1 <= f_legal && written[f_widx];
            end
        end
    end

    // use1 low (reset, unwritten, illegal) forces the fill word past the unreset array read
    assign instr1 = use1 ? rdata : FILL_WORD;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic        v2;
            logic        err2;
            logic [31:0] instr2;

            always_ff @(posedge clk or negedge rst_int_n) begin
                if (!rst_int_n) begin
                    v2     <= 1'b0;
                    err2   <= 1'b0;
                    instr2 <= FILL_WORD;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        err2   <= err1;
                        instr2 <= instr1;
                    end
                end
            end

            assign fetch_valid = v2;
            assign fetch_err   = err2;
            assign fetch_instr = instr2;
            assign drain_busy  = v1;
        end else begin : g_lat1
            assign fetch_valid = v1;
            assign fetch_err   = err1;
            assign fetch_instr = instr1;
            assign drain_busy  = 1'b0;
        end
    endgenerate

endmodule
